// File: rtl/cci_mpf_event_ctr_pkg.sv
// Shared definitions for the MPF event counter bank.
//   idx_width()  : read-index width for a bank of n counters (never below 1)
//   OVF_BIT      : bit of the 64-bit read word that carries the overflow flag
//   mpf_event_e  : standard MPF event numbering shared by CSR decode and shims
package cci_mpf_event_ctr_pkg;

  localparam int unsigned OVF_BIT = 63;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [5:0] {
    EVT_VTP_4KB_HIT            = 6'd0,
    EVT_VTP_4KB_MISS           = 6'd1,
    EVT_VTP_2MB_HIT            = 6'd2,
    EVT_VTP_2MB_MISS           = 6'd3,
    EVT_VTP_PT_WALK_BUSY       = 6'd4,
    EVT_VTP_FAILED_TRANSLATION = 6'd5,
    EVT_WRO_READ_CONFLICT      = 6'd6,
    EVT_WRO_WRITE_CONFLICT     = 6'd7,
    EVT_VC_MAP_REMAP           = 6'd8,
    EVT_PWRITE                 = 6'd9
  } mpf_event_e;

  localparam int unsigned N_STD_EVENTS = 10;

endpackage

// File: rtl/cci_mpf_event_ctr_one.sv
// One event counter: live accumulator, sticky overflow flag and shadow copy.
//   clk, reset_n     : clock, asynchronous active-low reset
//   inc, en          : registered increment and its enable (applied this edge)
//   clr              : zero live counter and overflow flag (wins over inc)
//   snap             : copy pre-update live value and flag into the shadow
//   shadow, shadow_ovf : snapshot seen by the MMIO read mux
module cci_mpf_event_ctr_one
  import cci_mpf_event_ctr_pkg::*;
#(
  parameter int INC_WIDTH = 1,
  parameter int CTR_WIDTH = 48,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 snap,
  output logic [CTR_WIDTH-1:0] shadow,
  output logic                 shadow_ovf
);

  logic [CTR_WIDTH-1:0] live;
  logic                 ovf;
  logic [CTR_WIDTH:0]   sum;
  logic [CTR_WIDTH-1:0] live_nxt;
  logic                 ovf_nxt;

  // Sum is one bit wider than the counter so the carry flags overflow.
  always_comb begin
    sum      = {1'b0, live} + {{(CTR_WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
    live_nxt = live;
    ovf_nxt  = ovf;
    if (en) begin
      if (sum[CTR_WIDTH]) begin
        ovf_nxt  = 1'b1;
        live_nxt = (SATURATE != 0) ? '1 : sum[CTR_WIDTH-1:0];
      end else begin
        live_nxt = sum[CTR_WIDTH-1:0];
      end
    end
  end

  // Snapshot takes the value before this edge's update, so a concurrent
  // clear yields read-and-reset and a concurrent increment stays in live.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live       <= '0;
      ovf        <= 1'b0;
      shadow     <= '0;
      shadow_ovf <= 1'b0;
    end else begin
      if (snap) begin
        shadow     <= live;
        shadow_ovf <= ovf;
      end
      if (clr) begin
        live <= '0;
        ovf  <= 1'b0;
      end else begin
        live <= live_nxt;
        ovf  <= ovf_nxt;
      end
    end
  end

endmodule

// File: rtl/cci_mpf_event_counter_bank.sv
// Bank of N_EVENTS event counters with atomic snapshot, clear and MMIO read.
//   clk, reset_n   : clock, asynchronous active-low reset
//   evt_inc        : per-counter increment, slice i = counter i
//   evt_enable     : per-counter accumulate enable, sampled with evt_inc
//   snap_req       : copy all live counters into the shadows
//   clr_req        : zero all live counters and overflow flags
//   rd_req, rd_idx : read one shadow counter
//   rd_rsp_valid   : one-cycle response strobe
//   rd_rsp_data    : {ovf, zero pad, shadow}; 0 for an out-of-range index
module cci_mpf_event_counter_bank
  import cci_mpf_event_ctr_pkg::*;
#(
  parameter int N_EVENTS  = 16,
  parameter int INC_WIDTH = 1,
  parameter int CTR_WIDTH = 48,
  parameter int SATURATE  = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_EVENTS*INC_WIDTH-1:0]   evt_inc,
  input  logic [N_EVENTS-1:0]             evt_enable,
  input  logic                            snap_req,
  input  logic                            clr_req,
  input  logic                            rd_req,
  input  logic [idx_width(N_EVENTS)-1:0]  rd_idx,
  output logic                            rd_rsp_valid,
  output logic [63:0]                     rd_rsp_data
);

  logic [N_EVENTS*INC_WIDTH-1:0] e1_inc;
  logic [N_EVENTS-1:0]           e1_en;
  logic [CTR_WIDTH-1:0]          shadow [N_EVENTS];
  logic [N_EVENTS-1:0]           shadow_ovf;
  logic [63:0]                   rd_word;

  // Input stage: isolates the shim event wires from the adder timing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e1_inc <= '0;
      e1_en  <= '0;
    end else begin
      e1_inc <= evt_inc;
      e1_en  <= evt_enable;
    end
  end

  for (genvar i = 0; i < N_EVENTS; i++) begin : g_ctr
    cci_mpf_event_ctr_one #(
      .INC_WIDTH (INC_WIDTH),
      .CTR_WIDTH (CTR_WIDTH),
      .SATURATE  (SATURATE)
    ) u_ctr (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc        (e1_inc[i*INC_WIDTH +: INC_WIDTH]),
      .en         (e1_en[i]),
      .clr        (clr_req),
      .snap       (snap_req),
      .shadow     (shadow[i]),
      .shadow_ovf (shadow_ovf[i])
    );
  end

  always_comb begin
    rd_word = '0;
    if (int'(rd_idx) < N_EVENTS) begin
      rd_word[CTR_WIDTH-1:0] = shadow[rd_idx];
      rd_word[OVF_BIT]       = shadow_ovf[rd_idx];
    end
  end

  // Response data is only loaded on a request so it holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
    end else begin
      rd_rsp_valid <= rd_req;
      if (rd_req) begin
        rd_rsp_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_event_counter_bank.sv
module tb_cci_mpf_event_counter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, snap_req, clr_req, rd_req;
  logic [15:0] inc_a, en_a;
  logic [3:0]  idx_a;
  logic [11:0] inc_b, inc_c;
  logic [2:0]  en_b, en_c;
  logic [1:0]  idx_b, idx_c;
  logic        v [3];
  logic [63:0] d [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: default pulse bank; 1: 4-bit inc, 8-bit saturating; 2: wrapping.
  cci_mpf_event_counter_bank u_a (
    .clk(clk), .reset_n(reset_n), .evt_inc(inc_a), .evt_enable(en_a),
    .snap_req(snap_req), .clr_req(clr_req), .rd_req(rd_req), .rd_idx(idx_a),
    .rd_rsp_valid(v[0]), .rd_rsp_data(d[0]));

  cci_mpf_event_counter_bank #(.N_EVENTS(3), .INC_WIDTH(4), .CTR_WIDTH(8), .SATURATE(1)) u_s (
    .clk(clk), .reset_n(reset_n), .evt_inc(inc_b), .evt_enable(en_b),
    .snap_req(snap_req), .clr_req(clr_req), .rd_req(rd_req), .rd_idx(idx_b),
    .rd_rsp_valid(v[1]), .rd_rsp_data(d[1]));

  cci_mpf_event_counter_bank #(.N_EVENTS(3), .INC_WIDTH(4), .CTR_WIDTH(8), .SATURATE(0)) u_w (
    .clk(clk), .reset_n(reset_n), .evt_inc(inc_c), .evt_enable(en_c),
    .snap_req(snap_req), .clr_req(clr_req), .rd_req(rd_req), .rd_idx(idx_c),
    .rd_rsp_valid(v[2]), .rd_rsp_data(d[2]));

  // Reference model: plain integer counts per instance/counter.
  int unsigned     nev [3] = '{16, 3, 3};
  int unsigned     cw  [3] = '{48, 8, 8};
  bit              sat [3] = '{1'b1, 1'b1, 1'b0};
  longint unsigned mcnt [3][16];
  longint unsigned mpend[3][16];
  longint unsigned msh  [3][16];
  bit              movf [3][16];
  bit              mshovf[3][16];
  logic [63:0]     exp_rd [3];

  function automatic longint unsigned cur_inc(int k, int i);
    case (k)
      0:       return en_a[i] ? 64'(inc_a[i]) : 64'd0;
      1:       return en_b[i] ? 64'(inc_b[i*4 +: 4]) : 64'd0;
      default: return en_c[i] ? 64'(inc_c[i*4 +: 4]) : 64'd0;
    endcase
  endfunction

  function automatic int cur_idx(int k);
    case (k)
      0:       return int'(idx_a);
      1:       return int'(idx_b);
      default: return int'(idx_c);
    endcase
  endfunction

  function automatic logic [63:0] exp_word(int k, int idx);
    logic [63:0] w;
    w = '0;
    if (idx < int'(nev[k])) begin
      w     = msh[k][idx];
      w[63] = mshovf[k][idx];
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) begin
        mcnt[k][i] = 0; mpend[k][i] = 0; msh[k][i] = 0;
        movf[k][i] = 0; mshovf[k][i] = 0;
      end
  endtask

  // One clock edge: apply the spec rules to the model, then step off the edge.
  task automatic tick();
    longint unsigned mx, s;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        exp_rd[k] = exp_word(k, cur_idx(k));
        mx = (64'd1 << cw[k]) - 64'd1;
        for (int i = 0; i < int'(nev[k]); i++) begin
          if (snap_req) begin
            msh[k][i] = mcnt[k][i];
            mshovf[k][i] = movf[k][i];
          end
          if (clr_req) begin
            mcnt[k][i] = 0;
            movf[k][i] = 0;
          end else begin
            s = mcnt[k][i] + mpend[k][i];
            if (s > mx) begin
              movf[k][i] = 1;
              mcnt[k][i] = sat[k] ? mx : s - mx - 64'd1;
            end else begin
              mcnt[k][i] = s;
            end
          end
          mpend[k][i] = cur_inc(k, i);
        end
      end
    end
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(int ia, int ib, int ic, bit snap);
    logic [63:0] hold [3];
    idx_a = 4'(ia); idx_b = 2'(ib); idx_c = 2'(ic);
    rd_req = 1'b1; snap_req = snap;
    tick();
    rd_req = 1'b0; snap_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rsp_valid[%0d] idx=%0d", k, cur_idx(k)), 64'(v[k]), 64'd1);
      chk($sformatf("rsp_data[%0d] idx=%0d", k, cur_idx(k)), d[k], exp_rd[k]);
      hold[k] = exp_rd[k];
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rsp_valid_drop[%0d]", k), 64'(v[k]), 64'd0);
      chk($sformatf("rsp_data_hold[%0d]", k), d[k], hold[k]);
    end
  endtask

  task automatic do_snap();
    snap_req = 1'b1; tick(); snap_req = 1'b0;
  endtask

  task automatic do_clr();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
  endtask

  task automatic drain();
    inc_a = '0; inc_b = '0; inc_c = '0;
    tick(); tick();
  endtask

  initial begin
    reset_n = 1'b0; snap_req = 1'b0; clr_req = 1'b0; rd_req = 1'b0;
    inc_a = '0; inc_b = '0; inc_c = '0;
    en_a = '1; en_b = '1; en_c = '1;
    idx_a = '0; idx_b = '0; idx_c = '0;
    model_reset();
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Reset state, including index 3 on the 3-counter banks (out of range).
    for (int i = 0; i < 16; i++) rd(i, i % 4, (i + 1) % 4, 1'b0);
    chk("reset_oor", d[1], 64'd0);

    // 100 pulses on event 3.
    inc_a = 16'h0008;
    repeat (100) tick();
    drain();
    do_snap();
    rd(3, 0, 0, 1'b0);
    chk("pulse100", d[0], 64'd100);
    rd(2, 0, 0, 1'b0);
    chk("pulse_other", d[0], 64'd0);

    // 100 pulses with enable dropped for 40 of them.
    do_clr();
    inc_a = 16'h0008;
    for (int c = 0; c < 100; c++) begin
      en_a[3] = (c >= 30 && c < 70) ? 1'b0 : 1'b1;
      tick();
    end
    en_a = '1;
    drain();
    do_snap();
    rd(3, 0, 0, 1'b0);
    chk("pulse_gated", d[0], 64'd60);

    // Multi-bit overflow: 18 x 0xF into 8-bit counters.
    do_clr();
    inc_b = 12'h00F; inc_c = 12'h00F;
    repeat (18) tick();
    drain();
    do_snap();
    rd(0, 0, 0, 1'b0);
    chk("saturate", d[1], 64'h8000_0000_0000_00FF);
    chk("wrap", d[2], 64'h8000_0000_0000_000E);

    // Clear discards the increment held in the input stage.
    do_clr();
    inc_a = 16'h0001; repeat (5) tick();
    drain();
    inc_a = 16'h0001; tick(); inc_a = '0;
    do_clr();
    drain();
    do_snap();
    rd(0, 0, 0, 1'b0);
    chk("clr_wins", d[0], 64'd0);

    // Increment sampled on the clear edge survives.
    inc_a = 16'h0001; repeat (5) tick();
    drain();
    inc_a = 16'h0001; tick();
    do_clr();
    drain();
    do_snap();
    rd(0, 0, 0, 1'b0);
    chk("clr_sampled", d[0], 64'd1);

    // Snap + clear together: read-and-reset.
    do_clr();
    inc_a = 16'h0020; repeat (77) tick();
    drain();
    snap_req = 1'b1; clr_req = 1'b1; tick(); snap_req = 1'b0; clr_req = 1'b0;
    rd(5, 0, 0, 1'b0);
    chk("snap_clr", d[0], 64'd77);
    rd(5, 0, 0, 1'b1);
    chk("snap_same_cycle_rd", d[0], 64'd77);
    rd(5, 0, 0, 1'b0);
    chk("snap_empty", d[0], 64'd0);

    // Random increments, enables, snaps and clears.
    for (int c = 0; c < 300; c++) begin
      inc_a = 16'($urandom); en_a = 16'($urandom);
      inc_b = 12'($urandom); en_b = 3'($urandom);
      inc_c = 12'($urandom); en_c = 3'($urandom);
      snap_req = ($urandom_range(0, 15) == 0);
      clr_req  = ($urandom_range(0, 31) == 0);
      tick();
      if ((c % 25) == 0) begin
        snap_req = 1'b0; clr_req = 1'b0;
        rd($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end
    end
    snap_req = 1'b0; clr_req = 1'b0;
    en_a = '1; en_b = '1; en_c = '1;
    drain();
    do_snap();
    for (int i = 0; i < 16; i++) rd(i, i % 4, (i + 2) % 4, 1'b0);

    // Reset asserted between a read request and its response edge.
    idx_a = 4'd3; idx_b = 2'd0; idx_c = 2'd0;
    rd_req = 1'b1;
    #2 reset_n = 1'b0;
    #1 rd_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 3; k++) chk($sformatf("rst_valid[%0d]", k), 64'(v[k]), 64'd0);
    end
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) chk($sformatf("rel_valid[%0d]", k), 64'(v[k]), 64'd0);
    do_snap();
    for (int i = 0; i < 16; i++) rd(i, i % 4, (i + 3) % 4, 1'b0);
    chk("post_reset_zero", d[0], 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
